// File: rtl/pdp6_key_pkg.sv
// Shared definitions for the console key sequencer: FSM states and the
// packed script-entry layout {last, key, delay, hold}.
package pdp6_key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    HOLD,
    NEXT
  } state_t;

  localparam int unsigned NKEYS_DEF = 12;
  localparam int unsigned CNTW_DEF  = 16;
  localparam int unsigned HOLD_LSB  = 0;

  function automatic int unsigned key_w(input int unsigned nkeys);
    return (nkeys > 1) ? $clog2(nkeys) : 1;
  endfunction

  localparam int unsigned KW_DEF = key_w(NKEYS_DEF);

  function automatic int unsigned delay_lsb(input int unsigned cntw);
    return cntw;
  endfunction

  function automatic int unsigned key_lsb(input int unsigned cntw);
    return 2 * cntw;
  endfunction

  function automatic int unsigned last_bit(input int unsigned kw, input int unsigned cntw);
    return 2 * cntw + kw;
  endfunction

  function automatic int unsigned entry_w(input int unsigned kw, input int unsigned cntw);
    return kw + 2 * cntw + 1;
  endfunction

endpackage

// File: rtl/key_sequencer_if.sv
// Script-write, run-control and key/status signals of the key sequencer.
interface key_sequencer_if
  import pdp6_key_pkg::*;
#(
  parameter int unsigned NKEYS = 12,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNTW  = 16
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = entry_w(key_w(NKEYS), CNTW);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [EW-1:0]    wr_data;
  logic             start;
  logic             abort;
  logic             stop_cond;
  logic             repeat_en;
  logic [NKEYS-1:0] keys;
  logic             busy;
  logic             done;
  logic             halted;
  logic [AW-1:0]    step;

  modport master (
    output wr_en, wr_addr, wr_data, start, abort, stop_cond, repeat_en,
    input  keys, busy, done, halted, step
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, abort, stop_cond, repeat_en,
    output keys, busy, done, halted, step
  );
endinterface

// File: rtl/key_script_ram.sv
// Script store: one synchronous write port, one asynchronous read port.
// No reset, so a script survives a sequencer reset.
module key_script_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 37
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/key_sequencer.sv
// Plays a stored script of console key presses: per entry, wait `delay`,
// hold one key for `hold`+1 cycles, then advance, wrap or finish.
module key_sequencer
  import pdp6_key_pkg::*;
#(
  parameter int unsigned NKEYS = 12,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNTW  = 16
) (
  input logic            clk,
  input logic            reset,
  key_sequencer_if.slave bus
);
  localparam int unsigned KW       = key_w(NKEYS);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned EW       = entry_w(KW, CNTW);
  localparam int unsigned DLY_LSB  = delay_lsb(CNTW);
  localparam int unsigned KEY_LSB  = key_lsb(CNTW);
  localparam int unsigned LAST_BIT = last_bit(KW, CNTW);

  state_t          state_q;
  logic [CNTW-1:0] cnt_q;
  logic [AW-1:0]   step_q;
  logic            last_q;
  logic            done_q;
  logic            halted_q;

  logic [AW-1:0]   rd_addr;
  logic [AW-1:0]   next_step;
  logic [EW-1:0]   rd_data;
  logic [CNTW-1:0] e_hold;
  logic [CNTW-1:0] e_delay;
  logic [KW-1:0]   e_key;
  logic            e_last;
  logic            kill;
  logic            key_act;

  key_script_ram #(
    .DEPTH(DEPTH),
    .WIDTH(EW)
  ) u_ram (
    .clk     (clk),
    .we_i    (bus.wr_en & ~reset),
    .waddr_i (bus.wr_addr),
    .wdata_i (bus.wr_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign e_hold  = rd_data[HOLD_LSB +: CNTW];
  assign e_delay = rd_data[DLY_LSB +: CNTW];
  assign e_key   = rd_data[KEY_LSB +: KW];
  assign e_last  = rd_data[LAST_BIT];

  assign kill      = bus.stop_cond | bus.abort;
  assign next_step = last_q ? '0 : step_q + AW'(1);

  // Single read port: `last` is latched on entering HOLD so that NEXT can
  // address the following entry and preload its delay in the same cycle.
  always_comb begin
    rd_addr = step_q;
    case (state_q)
      IDLE:    rd_addr = '0;
      NEXT:    rd_addr = next_step;
      default: rd_addr = step_q;
    endcase
  end

  assign key_act = (state_q == HOLD) && !kill && !reset;

  always_comb begin
    bus.keys = '0;
    for (int unsigned i = 0; i < NKEYS; i++)
      bus.keys[i] = key_act && (32'(e_key) == i);
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.halted = halted_q;
  assign bus.step   = step_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      step_q   <= '0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE && kill) begin
        halted_q <= 1'b1;
        state_q  <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start) begin
              step_q   <= '0;
              cnt_q    <= e_delay;
              halted_q <= 1'b0;
              state_q  <= DELAY;
            end
          end
          DELAY: begin
            if (cnt_q == '0) begin
              cnt_q   <= e_hold;
              last_q  <= e_last;
              state_q <= HOLD;
            end else begin
              cnt_q <= cnt_q - CNTW'(1);
            end
          end
          HOLD: begin
            if (cnt_q == '0) state_q <= NEXT;
            else             cnt_q   <= cnt_q - CNTW'(1);
          end
          NEXT: begin
            if (!last_q || bus.repeat_en) begin
              step_q  <= next_step;
              cnt_q   <= e_delay;
              state_q <= DELAY;
            end else begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_key_sequencer.sv
// Bench for key_sequencer: single-entry timing table plus multi-entry,
// repeat, halt, reset and wrap sequences checked against a key-event scoreboard.
module tb_key_sequencer;
  localparam int unsigned NKEYS = 12;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNTW  = 16;
  localparam int unsigned AW    = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  key_sequencer_if #(.NKEYS(NKEYS), .DEPTH(DEPTH), .CNTW(CNTW)) bus ();

  key_sequencer #(.NKEYS(NKEYS), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [NKEYS-1:0] k;
    int               rise;
    int               len;
  } ev_t;

  typedef struct {
    int               key;
    int               d;
    int               h;
    int               rise;
    int               len;
    logic [NKEYS-1:0] kv;
    int               done;
  } vec_t;

  ev_t ev_q[$];
  int  done_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  bit  mon_en = 1'b0;

  int s_k[DEPTH];
  int s_d[DEPTH];
  int s_h[DEPTH];
  bit s_last[DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic finish_ev(input logic [NKEYS-1:0] k, input int rise, input int len);
    ev_t e;
    if (ev_q.size() == 0) begin
      check("ev_unexpected", int'(k), 0);
    end else begin
      e = ev_q.pop_front();
      check("ev_key", int'(k), int'(e.k));
      check("ev_rise", rise, e.rise);
      check("ev_len", len, e.len);
    end
  endtask

  // Key-press monitor: turns level changes on keys into {key, rise, length}.
  logic [NKEYS-1:0] prev_k = '0;
  int rise_c = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.keys != '0) check("keys_onehot", int'($onehot(bus.keys)), 1);
      if (bus.keys != prev_k) begin
        if (prev_k != '0) finish_ev(prev_k, rise_c, cyc - rise_c);
        if (bus.keys != '0) rise_c = cyc;
        prev_k = bus.keys;
      end
      if (bus.done) begin
        if (done_q.size() == 0) check("done_unexpected", cyc, -1);
        else check("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycle(input int c);
    while (cyc < c) tick();
  endtask

  task automatic write_entry(input int addr, input bit last, input int key, input int d, input int h);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(addr);
    bus.wr_data = {last, 4'(key), 16'(d), 16'(h)};
    tick();
    bus.wr_en   = 1'b0;
    s_k[addr]    = key;
    s_d[addr]    = d;
    s_h[addr]    = h;
    s_last[addr] = last;
  endtask

  task automatic start_run(output int c0);
    bus.start = 1'b1;
    c0 = cyc;
    tick();
    bus.start = 1'b0;
  endtask

  // Expected key events for n entries walked from entry 0 of the mirror script.
  task automatic push_seq(input int c0, input int n, input bit with_done);
    int t;
    int s;
    int rise;
    ev_t e;
    t = c0 + 1;
    s = 0;
    for (int i = 0; i < n; i++) begin
      rise = t + s_d[s] + 1;
      if (s_k[s] < int'(NKEYS)) begin
        e.k = '0;
        e.k[s_k[s]] = 1'b1;
        e.rise = rise;
        e.len = s_h[s] + 1;
        ev_q.push_back(e);
      end
      t = rise + s_h[s] + 2;
      s = s_last[s] ? 0 : (s + 1) % int'(DEPTH);
    end
    if (with_done) done_q.push_back(t);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.busy && n < limit);
    check("idle_timeout", int'(n >= limit), 0);
  endtask

  task automatic settle_and_drain(input string tag);
    tick();
    @(negedge clk);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done_low"}, int'(bus.done), 0);
    check({tag, "_ev_left"}, ev_q.size(), 0);
    check({tag, "_done_left"}, done_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[6];
    int   c0;
    ev_t  e;

    vt[0] = '{1,  3, 4, 5, 5, 12'h002, 11};
    vt[1] = '{0,  0, 0, 2, 1, 12'h001, 4};
    vt[2] = '{11, 2, 1, 4, 2, 12'h800, 7};
    vt[3] = '{15, 1, 2, 3, 3, 12'h000, 7};
    vt[4] = '{7,  0, 5, 2, 6, 12'h080, 9};
    vt[5] = '{6,  5, 0, 7, 1, 12'h040, 9};

    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.stop_cond = 1'b0;
    bus.repeat_en = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_keys", int'(bus.keys), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_halted", int'(bus.halted), 0);
    check("rst_step", int'(bus.step), 0);
    tick();
    reset = 1'b0;
    mon_en = 1'b1;

    // Single-entry runs with hand-derived timing
    for (int i = 0; i < 6; i++) begin
      write_entry(0, 1'b1, vt[i].key, vt[i].d, vt[i].h);
      start_run(c0);
      if (vt[i].kv != '0) begin
        e.k = vt[i].kv;
        e.rise = c0 + vt[i].rise;
        e.len = vt[i].len;
        ev_q.push_back(e);
      end
      done_q.push_back(c0 + vt[i].done);
      wait_idle(64);
      settle_and_drain("tbl");
      check("tbl_halted", int'(bus.halted), 0);
    end

    // Three entries; start pulses while busy and during NEXT are ignored
    write_entry(0, 1'b0, 0, 0, 0);
    write_entry(1, 1'b0, 5, 0, 0);
    write_entry(2, 1'b1, 11, 0, 0);
    start_run(c0);
    push_seq(c0, 3, 1'b1);
    wait_cycle(c0 + 3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_cycle(c0 + 9);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_idle(64);
    settle_and_drain("three");

    // Repeat: 0,5,0,5 then stop after the next last entry
    write_entry(0, 1'b0, 0, 1, 1);
    write_entry(1, 1'b1, 5, 0, 2);
    bus.repeat_en = 1'b1;
    start_run(c0);
    push_seq(c0, 4, 1'b1);
    wait_cycle(c0 + 18);
    bus.repeat_en = 1'b0;
    wait_idle(64);
    settle_and_drain("repeat");

    // stop_cond mid-HOLD of key 3
    write_entry(0, 1'b1, 3, 1, 6);
    start_run(c0);
    e.k = 12'h008;
    e.rise = c0 + 3;
    e.len = 2;
    ev_q.push_back(e);
    wait_cycle(c0 + 5);
    bus.stop_cond = 1'b1;
    @(negedge clk);
    check("stop_keys_same", int'(bus.keys), 0);
    check("stop_busy_same", int'(bus.busy), 1);
    tick();
    bus.stop_cond = 1'b0;
    @(negedge clk);
    check("stop_busy", int'(bus.busy), 0);
    check("stop_halted", int'(bus.halted), 1);
    repeat (3) tick();
    @(negedge clk);
    check("halted_sticky", int'(bus.halted), 1);
    check("stop_ev_left", ev_q.size(), 0);

    // abort together with stop_cond in DELAY, then a clean rerun clears halted
    write_entry(0, 1'b1, 2, 3, 1);
    start_run(c0);
    wait_cycle(c0 + 2);
    bus.abort = 1'b1;
    bus.stop_cond = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.stop_cond = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_halted", int'(bus.halted), 1);
    start_run(c0);
    push_seq(c0, 1, 1'b1);
    tick();
    @(negedge clk);
    check("rerun_halted_clr", int'(bus.halted), 0);
    wait_idle(64);
    settle_and_drain("rerun");

    // Reset during DELAY of step 2, then replay with the preserved script
    write_entry(0, 1'b0, 0, 0, 0);
    write_entry(1, 1'b0, 5, 0, 0);
    write_entry(2, 1'b1, 11, 4, 0);
    start_run(c0);
    push_seq(c0, 2, 1'b0);
    wait_cycle(c0 + 8);
    @(negedge clk);
    check("pre_rst_step", int'(bus.step), 2);
    check("pre_rst_busy", int'(bus.busy), 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_keys", int'(bus.keys), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_done", int'(bus.done), 0);
    check("mid_rst_halted", int'(bus.halted), 0);
    check("mid_rst_step", int'(bus.step), 0);
    start_run(c0);
    push_seq(c0, 3, 1'b1);
    wait_idle(64);
    settle_and_drain("replay");

    // Unmarked script wraps from DEPTH-1 back to 0
    for (int i = 0; i < int'(DEPTH); i++) write_entry(i, 1'b0, i % int'(NKEYS), 0, 0);
    start_run(c0);
    push_seq(c0, 18, 1'b0);
    wait_cycle(c0 + 47);
    @(negedge clk);
    check("wrap_step_last", int'(bus.step), 15);
    wait_cycle(c0 + 50);
    @(negedge clk);
    check("wrap_step_zero", int'(bus.step), 0);
    wait_cycle(c0 + 54);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    settle_and_drain("wrap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
